// File: rtl/frame_assembler_pkg.sv
// Shared types, constants and helpers for the frame assembler.
package frame_assembler_pkg;

  // Default frame geometry
  localparam int unsigned DefSamples        = 500;
  localparam int unsigned DefParamsPerFrame = 12;
  localparam int unsigned DefParamTable     = 48;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StSound,
    StParam,
    StDone
  } state_e;

  // Ceiling log2, never below 1 so every derived bus has at least one bit
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 1;
    while ((64'd1 << res) < 64'(value)) res++;
    return res;
  endfunction

endpackage

// File: rtl/frame_assembler_tick_edge.sv
// Registers the frame tick and produces a one-clock pulse on its rising edge.
module frame_assembler_tick_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic msec,
  output logic tick
);

  logic msec_d, msec_q;

  // Next-state for the delayed copy of msec
  always_comb begin
    msec_d = msec;
  end

  // Delay register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) msec_q <= 1'b0;
    else        msec_q <= msec_d;
  end

  assign tick = msec & ~msec_q;

endmodule

// File: rtl/frame_assembler.sv
// Ping-pong frame builder: sound words then flight words into one bank per tick,
// finished bank handed to the transmitter via tx_req/tx_ack.
module frame_assembler
  import frame_assembler_pkg::*;
#(
  parameter int unsigned CHANNELS         = 2,
  parameter int unsigned SAMPLE_W         = 16,
  parameter int unsigned SAMPLES          = DefSamples,
  parameter int unsigned PARAMS_PER_FRAME = DefParamsPerFrame,
  parameter int unsigned PARAM_TABLE      = DefParamTable,
  localparam int unsigned WORD_W          = CHANNELS * SAMPLE_W,
  localparam int unsigned FRAME_WORDS     = SAMPLES + PARAMS_PER_FRAME,
  localparam int unsigned SA_W            = clog2(SAMPLES),
  localparam int unsigned PA_W            = clog2(PARAM_TABLE),
  localparam int unsigned WA_W            = clog2(2 * FRAME_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              timer,
  input  logic              msec,
  output logic [SA_W-1:0]   snd_addr,
  input  logic [WORD_W-1:0] snd_data,
  output logic [PA_W-1:0]   prm_addr,
  input  logic [WORD_W-1:0] prm_data,
  output logic              wr_en,
  output logic [WA_W-1:0]   wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              tx_req,
  output logic              tx_bank,
  input  logic              tx_ack,
  output logic              frame_rdy,
  output logic [3:0]        frame_cnt,
  output logic [7:0]        overrun_cnt,
  output logic [7:0]        drop_cnt
);

  localparam int unsigned PC_W = clog2(PARAMS_PER_FRAME + 1);

  logic tick;

  frame_assembler_tick_edge u_tick_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .msec  (msec),
    .tick  (tick)
  );

  state_e            state_d, state_q;
  logic              timer_seen_d, timer_seen_q;
  logic              bank_d, bank_q;
  logic [SA_W-1:0]   snd_addr_d, snd_addr_q;
  logic [PA_W-1:0]   prm_addr_d, prm_addr_q;
  logic [PC_W-1:0]   prm_cnt_d, prm_cnt_q;
  logic              wr_en_d, wr_en_q;
  logic              wr_sel_d, wr_sel_q;
  logic [WA_W-1:0]   wr_addr_d, wr_addr_q;
  logic              tx_req_d, tx_req_q;
  logic              tx_bank_d, tx_bank_q;
  logic              frame_rdy_d, frame_rdy_q;
  logic [3:0]        frame_cnt_d, frame_cnt_q;
  logic [7:0]        overrun_d, overrun_q;
  logic [7:0]        drop_d, drop_q;
  logic [WA_W-1:0]   bank_base;

  assign bank_base = bank_q ? WA_W'(FRAME_WORDS) : '0;

  // Next-state: FSM, address counters, handshake and statistics
  always_comb begin
    state_d      = state_q;
    timer_seen_d = timer_seen_q | timer;
    bank_d       = bank_q;
    snd_addr_d   = snd_addr_q;
    prm_addr_d   = prm_addr_q;
    prm_cnt_d    = prm_cnt_q;
    wr_en_d      = 1'b0;
    wr_sel_d     = wr_sel_q;
    wr_addr_d    = wr_addr_q;
    tx_req_d     = tx_req_q;
    tx_bank_d    = tx_bank_q;
    frame_rdy_d  = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    overrun_d    = overrun_q;
    drop_d       = drop_q;

    if (tx_req_q && tx_ack) tx_req_d = 1'b0;

    // Ticks during assembly are counted and thrown away
    if (tick && (state_q inside {StSound, StParam, StDone}) && (overrun_q != 8'hFF)) begin
      overrun_d = overrun_q + 8'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (timer_seen_d) state_d = StWait;
      end
      StWait: begin
        if (tick) begin
          frame_rdy_d = 1'b1;
          frame_cnt_d = frame_cnt_q + 4'd1;
          snd_addr_d  = '0;
          state_d     = StSound;
        end
      end
      StSound: begin
        wr_en_d   = 1'b1;
        wr_sel_d  = 1'b0;
        wr_addr_d = bank_base + WA_W'(snd_addr_q);
        if (snd_addr_q == SA_W'(SAMPLES - 1)) state_d = StParam;
        else snd_addr_d = snd_addr_q + 1'b1;
      end
      StParam: begin
        if (prm_cnt_q != PC_W'(PARAMS_PER_FRAME)) begin
          wr_en_d    = 1'b1;
          wr_sel_d   = 1'b1;
          wr_addr_d  = bank_base + WA_W'(SAMPLES) + WA_W'(prm_cnt_q);
          prm_cnt_d  = prm_cnt_q + 1'b1;
          prm_addr_d = (prm_addr_q == PA_W'(PARAM_TABLE - 1)) ? '0 : prm_addr_q + 1'b1;
        end else begin
          // Extra cycle lets the last flight word land before DONE
          prm_cnt_d = '0;
          state_d   = StDone;
        end
      end
      StDone: begin
        // An ack in this same clock frees the slot, so the new bank is offered
        if (!tx_req_q || tx_ack) begin
          tx_req_d  = 1'b1;
          tx_bank_d = bank_q;
          bank_d    = ~bank_q;
        end else if (drop_q != 8'hFF) begin
          drop_d = drop_q + 8'd1;
        end
        state_d = StWait;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      timer_seen_q <= 1'b0;
      bank_q       <= 1'b0;
      snd_addr_q   <= '0;
      prm_addr_q   <= '0;
      prm_cnt_q    <= '0;
      wr_en_q      <= 1'b0;
      wr_sel_q     <= 1'b0;
      wr_addr_q    <= '0;
      tx_req_q     <= 1'b0;
      tx_bank_q    <= 1'b0;
      frame_rdy_q  <= 1'b0;
      frame_cnt_q  <= '0;
      overrun_q    <= '0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      timer_seen_q <= timer_seen_d;
      bank_q       <= bank_d;
      snd_addr_q   <= snd_addr_d;
      prm_addr_q   <= prm_addr_d;
      prm_cnt_q    <= prm_cnt_d;
      wr_en_q      <= wr_en_d;
      wr_sel_q     <= wr_sel_d;
      wr_addr_q    <= wr_addr_d;
      tx_req_q     <= tx_req_d;
      tx_bank_q    <= tx_bank_d;
      frame_rdy_q  <= frame_rdy_d;
      frame_cnt_q  <= frame_cnt_d;
      overrun_q    <= overrun_d;
      drop_q       <= drop_d;
    end
  end

  // Read data arrives one clock after its address, aligned with wr_en_q
  assign wr_data     = !wr_en_q ? '0 : (wr_sel_q ? prm_data : snd_data);
  assign snd_addr    = snd_addr_q;
  assign prm_addr    = prm_addr_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign tx_req      = tx_req_q;
  assign tx_bank     = tx_bank_q;
  assign frame_rdy   = frame_rdy_q;
  assign frame_cnt   = frame_cnt_q;
  assign overrun_cnt = overrun_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_frame_assembler.sv
// Self-checking bench for frame_assembler with default geometry (500 + 12 words).
module tb_frame_assembler;

  localparam int FW  = 512;
  localparam int NS  = 500;
  localparam int NPT = 48;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        timer = 1'b0;
  logic        msec = 1'b0;
  logic [8:0]  snd_addr;
  logic [31:0] snd_data = '0;
  logic [5:0]  prm_addr;
  logic [31:0] prm_data = '0;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic        tx_req;
  logic        tx_bank;
  logic        tx_ack = 1'b0;
  logic        frame_rdy;
  logic [3:0]  frame_cnt;
  logic [7:0]  overrun_cnt;
  logic [7:0]  drop_cnt;

  frame_assembler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .timer       (timer),
    .msec        (msec),
    .snd_addr    (snd_addr),
    .snd_data    (snd_data),
    .prm_addr    (prm_addr),
    .prm_data    (prm_data),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .tx_req      (tx_req),
    .tx_bank     (tx_bank),
    .tx_ack      (tx_ack),
    .frame_rdy   (frame_rdy),
    .frame_cnt   (frame_cnt),
    .overrun_cnt (overrun_cnt),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] snd_word(input int a);
    return {16'h5A5A, 16'(a)};
  endfunction

  function automatic logic [31:0] prm_word(input int a);
    return {16'hC3C3, 16'(a)};
  endfunction

  // Synchronous-read source memories
  always @(posedge clk) begin
    snd_data <= snd_word(int'(snd_addr));
    prm_data <= prm_word(int'(prm_addr));
  end

  int n_tests = 0;
  int n_fail  = 0;
  int wr_total = 0;
  int rdy_total = 0;
  int data_errs = 0;

  // Bus monitor: counts writes/frame starts and checks sound words by address
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        int idx;
        wr_total++;
        idx = int'(wr_addr) % FW;
        if (idx < NS && wr_data != snd_word(idx)) data_errs++;
        if (idx >= NS && wr_data[31:16] != 16'hC3C3) data_errs++;
      end
      if (frame_rdy) rdy_total++;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ack_pulse();
    tx_ack = 1'b1;
    step(1);
    tx_ack = 1'b0;
    chk("ack_clears_req", tx_req, 0);
  endtask

  // One tick, then cycle-by-cycle check of the whole frame up to tx_req
  task automatic run_frame(input string tag, input int bank, input int pstart,
                           input bit ack_done, input int exp_fc, input int exp_txb,
                           input int exp_drop);
    int errs;
    int idx;
    logic [31:0] exp_d;
    msec = 1'b1;
    step(1);
    msec = 1'b0;
    chk({tag, "_frame_rdy"}, frame_rdy, 1);
    chk({tag, "_snd_addr0"}, snd_addr, 0);
    chk({tag, "_frame_cnt"}, frame_cnt, exp_fc);
    errs = 0;
    for (int i = 0; i < FW; i++) begin
      step(1);
      exp_d = (i < NS) ? snd_word(i) : prm_word((pstart + i - NS) % NPT);
      if (!wr_en || int'(wr_addr) != bank * FW + i || wr_data != exp_d) errs++;
      if (i >= NS - 1 && int'(prm_addr) != (pstart + i - (NS - 1)) % NPT) errs++;
    end
    chk({tag, "_write_errs"}, errs, 0);
    step(1);
    chk({tag, "_wr_en_off"}, wr_en, 0);
    chk({tag, "_req_early"}, tx_req, ack_done ? 1 : tx_req);
    if (ack_done) tx_ack = 1'b1;
    step(1);
    tx_ack = 1'b0;
    chk({tag, "_tx_req"}, tx_req, 1);
    chk({tag, "_tx_bank"}, tx_bank, exp_txb);
    chk({tag, "_drop"}, drop_cnt, exp_drop);
    chk({tag, "_overrun"}, overrun_cnt, 0);
  endtask

  typedef struct {
    bit ack_before;
    bit ack_done;
    int bank;
    int pstart;
    int fc;
    int txb;
    int drop;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int w0;
    int r0;
    vecs[0] = '{0, 0, 0,  0, 1, 0, 0};
    vecs[1] = '{1, 0, 1, 12, 2, 1, 0};
    vecs[2] = '{1, 0, 0, 24, 3, 0, 0};
    vecs[3] = '{1, 0, 1, 36, 4, 1, 0};  // prm_addr wraps 47 -> 0
    vecs[4] = '{1, 0, 0,  0, 5, 0, 0};
    vecs[5] = '{0, 0, 1, 12, 6, 0, 1};  // dropped, bank 1 reused
    vecs[6] = '{0, 0, 1, 24, 7, 0, 2};  // dropped again
    vecs[7] = '{0, 1, 1, 36, 8, 1, 2};  // ack coincident with DONE

    step(3);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_tx_req", tx_req, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    rst_n = 1'b1;
    step(2);

    // Timer still low: ticks must be ignored
    for (int k = 0; k < 3; k++) begin
      msec = 1'b1;
      step(2);
      msec = 1'b0;
      step(10);
    end
    chk("no_timer_writes", wr_total, 0);
    chk("no_timer_frame_cnt", frame_cnt, 0);

    timer = 1'b1;
    step(2);
    timer = 1'b0;  // latched

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].ack_before) ack_pulse();
      run_frame($sformatf("vec%0d", v), vecs[v].bank, vecs[v].pstart, vecs[v].ack_done,
                vecs[v].fc, vecs[v].txb, vecs[v].drop);
    end

    // msec held high for 2000 clocks: one frame only
    ack_pulse();
    w0 = wr_total;
    r0 = rdy_total;
    msec = 1'b1;
    step(2000);
    msec = 1'b0;
    step(5);
    chk("held_frames", rdy_total - r0, 1);
    chk("held_writes", wr_total - w0, FW);
    chk("held_overrun", overrun_cnt, 0);
    chk("held_frame_cnt", frame_cnt, 9);
    chk("held_tx_bank", tx_bank, 0);

    // Tick every 300 clocks: every other tick is an overrun
    ack_pulse();
    w0 = wr_total;
    r0 = rdy_total;
    for (int k = 0; k < 4; k++) begin
      msec = 1'b1;
      step(1);
      msec = 1'b0;
      step(299);
    end
    step(600);
    chk("per_frames", rdy_total - r0, 2);
    chk("per_writes", wr_total - w0, 2 * FW);
    chk("per_overrun", overrun_cnt, 2);
    chk("per_frame_cnt", frame_cnt, 11);
    chk("per_drop", drop_cnt, 3);
    chk("per_tx_bank", tx_bank, 1);
    chk("data_errs", data_errs, 0);

    // Asynchronous reset in the middle of SOUND
    ack_pulse();
    msec = 1'b1;
    step(1);
    msec = 1'b0;
    step(100);
    chk("pre_rst_wr_en", wr_en, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_outputs",
        {wr_en, tx_req, tx_bank, frame_rdy, frame_cnt, overrun_cnt, drop_cnt,
         snd_addr, prm_addr, wr_addr, wr_data}, 0);
    step(2);
    rst_n = 1'b1;
    step(1);
    w0 = wr_total;
    msec = 1'b1;
    step(2);
    msec = 1'b0;
    step(20);
    chk("post_rst_idle_writes", wr_total - w0, 0);
    timer = 1'b1;
    step(2);
    run_frame("post_rst", 0, 0, 1'b0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
